dmem_access_ctrl: RTL and testbench

- Initiator-side controller for the byte-addressed data memory.
- Accepts one CPU load/store request at a time over a valid/ready handshake, translates the CPU address to a memory offset, and drives cs, DM_R and exactly one of DM_W_W/DM_W_H/DM_W_B for exactly one write cycle.
- Captures read data, then sign- or zero-extends it per op.
- Returns a registered response with an error flag. Sits between the CPU execute/mem stage and the data memory.

---
 rtl/dmem_access_pkg.sv | 43 ++++
 rtl/dmem_load_ext.sv | 21 ++
 rtl/dmem_access_ctrl.sv | 135 +++++++++++++
 tb/tb_dmem_access_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_pkg.sv
// Shared op/state encodings and op decode helpers for the data-memory access controller.
package dmem_access_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  function automatic logic [2:0] op_size(op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'd1;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      default:              return 3'd4;
    endcase
  endfunction

  function automatic logic is_load(op_t op);
    return (op <= OP_LW);
  endfunction

  // Strobe pattern as {word, half, byte}; loads yield no strobe.
  function automatic logic [2:0] wr_strobes(op_t op);
    case (op)
      OP_SW:   return 3'b100;
      OP_SH:   return 3'b010;
      OP_SB:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Combinational sign/zero extension of raw memory read data according to the load op.
module dmem_load_ext
  import dmem_access_pkg::*;
(
  input  op_t         op,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (op)
      OP_LB:   ext = {{24{raw[7]}}, raw[7:0]};
      OP_LBU:  ext = {24'd0, raw[7:0]};
      OP_LH:   ext = {{16{raw[15]}}, raw[15:0]};
      OP_LHU:  ext = {16'd0, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: one CPU load/store at a time, range-checked, registered strobes.
// Optional alignment checking is enabled by defining DMEM_ACCESS_ALIGN_CHECK_EN.
module dmem_access_ctrl
  import dmem_access_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned MEM_BYTES   = 1024,
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              cs,
  output logic              DM_R,
  output logic              DM_W_W,
  output logic              DM_W_H,
  output logic              DM_W_B,
  output logic [ADDR_W-1:0] DM_addr,
  output logic [31:0]       DM_data_in,
  input  logic [31:0]       DM_data_out
);

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state;
  op_t         op_q;
  logic [3:0]  wait_cnt;
  op_t         in_op;
  logic [31:0] offset;
  logic [32:0] span_end;
  logic        range_err;
  logic        align_err;
  logic        bad_req;
  logic [31:0] ext_data;

  assign in_op     = op_t'(req_op);
  assign offset    = req_addr - BASE_ADDR;
  assign span_end  = {1'b0, offset} + {30'd0, op_size(in_op)};
  assign range_err = (span_end > MEM_LIMIT);

`ifdef DMEM_ACCESS_ALIGN_CHECK_EN
  assign align_err = ((op_size(in_op) == 3'd2) && offset[0]) ||
                     ((op_size(in_op) == 3'd4) && (offset[1:0] != 2'b00));
`else
  assign align_err = 1'b0;
`endif

  assign bad_req = range_err || align_err;

  dmem_load_ext u_load_ext (
    .op  (op_q),
    .raw (DM_data_out),
    .ext (ext_data)
  );

  // Strobes are registered one edge ahead so they land only in the last ACCESS cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_q       <= OP_LB;
      wait_cnt   <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cs         <= 1'b0;
      DM_R       <= 1'b0;
      DM_W_W     <= 1'b0;
      DM_W_H     <= 1'b0;
      DM_W_B     <= 1'b0;
      DM_addr    <= '0;
      DM_data_in <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q      <= in_op;
            req_ready <= 1'b0;
            if (bad_req) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state      <= ST_ACCESS;
              wait_cnt   <= WAIT_INIT;
              cs         <= 1'b1;
              DM_R       <= is_load(in_op);
              DM_addr    <= offset[ADDR_W-1:0];
              DM_data_in <= req_wdata;
              if (WAIT_INIT == 4'd0)
                {DM_W_W, DM_W_H, DM_W_B} <= wr_strobes(in_op);
            end
          end
        end
        ST_ACCESS: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt == 4'd1)
              {DM_W_W, DM_W_H, DM_W_B} <= wr_strobes(op_q);
          end else begin
            state      <= ST_RESP;
            cs         <= 1'b0;
            DM_R       <= 1'b0;
            DM_W_W     <= 1'b0;
            DM_W_H     <= 1'b0;
            DM_W_B     <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= is_load(op_q) ? ext_data : '0;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl with a byte-array memory model.
module tb_dmem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- DUT with WAIT_CYCLES = 0 ----------------
  logic        rst0_n, req_valid, req_ready, resp_valid, resp_ready, resp_err;
  logic        cs, dm_r, dm_ww, dm_wh, dm_wb;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata, resp_rdata, dm_din, dm_dout;
  logic [10:0] dm_addr;

  dmem_access_ctrl #(.BASE_ADDR(32'h1001_0000), .MEM_BYTES(1024), .ADDR_W(11), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst0_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .cs(cs), .DM_R(dm_r), .DM_W_W(dm_ww), .DM_W_H(dm_wh), .DM_W_B(dm_wb),
    .DM_addr(dm_addr), .DM_data_in(dm_din), .DM_data_out(dm_dout)
  );

  logic [7:0]  mem [0:1023];
  int          nw = 0, nh = 0, nb = 0, ncs = 0, nmulti = 0;
  logic [10:0] last_addr = '0;
  logic [31:0] last_data = '0;
  int unsigned rd_idx;

  initial for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

  always_comb begin
    dm_dout = '0;
    rd_idx  = 0;
    for (int i = 0; i < 4; i++) begin
      rd_idx = 32'(dm_addr) + 32'(i);
      if (rd_idx < 1024) dm_dout[8*i +: 8] = mem[rd_idx];
    end
  end

  always @(posedge clk) begin
    if (cs) ncs++;
    if (dm_ww) nw++;
    if (dm_wh) nh++;
    if (dm_wb) nb++;
    if (32'(dm_ww) + 32'(dm_wh) + 32'(dm_wb) > 1) nmulti++;
    if (dm_ww || dm_wh || dm_wb) begin
      last_addr = dm_addr;
      last_data = dm_din;
    end
    if (cs && dm_wb) mem[32'(dm_addr)] <= dm_din[7:0];
    if (cs && dm_wh) begin
      mem[32'(dm_addr)]     <= dm_din[7:0];
      mem[32'(dm_addr) + 1] <= dm_din[15:8];
    end
    if (cs && dm_ww) begin
      mem[32'(dm_addr)]     <= dm_din[7:0];
      mem[32'(dm_addr) + 1] <= dm_din[15:8];
      mem[32'(dm_addr) + 2] <= dm_din[23:16];
      mem[32'(dm_addr) + 3] <= dm_din[31:24];
    end
  end

  // ---------------- DUT with WAIT_CYCLES = 3 ----------------
  logic        rstw_n, req_valid_w, req_ready_w, resp_valid_w, resp_ready_w, resp_err_w;
  logic        cs_w, dm_r_w, dm_ww_w, dm_wh_w, dm_wb_w;
  logic [2:0]  req_op_w;
  logic [31:0] req_addr_w, req_wdata_w, resp_rdata_w, dm_din_w;
  logic [31:0] dm_dout_w = 32'h1234_5678;
  logic [10:0] dm_addr_w;

  dmem_access_ctrl #(.BASE_ADDR(32'h1001_0000), .MEM_BYTES(1024), .ADDR_W(11), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rstw_n),
    .req_valid(req_valid_w), .req_ready(req_ready_w), .req_op(req_op_w),
    .req_addr(req_addr_w), .req_wdata(req_wdata_w),
    .resp_valid(resp_valid_w), .resp_ready(resp_ready_w),
    .resp_rdata(resp_rdata_w), .resp_err(resp_err_w),
    .cs(cs_w), .DM_R(dm_r_w), .DM_W_W(dm_ww_w), .DM_W_H(dm_wh_w), .DM_W_B(dm_wb_w),
    .DM_addr(dm_addr_w), .DM_data_in(dm_din_w), .DM_data_out(dm_dout_w)
  );

  int nw_w = 0, nh_w = 0, nb_w = 0, acc_run = 0, h_pos = 0;

  always @(posedge clk) begin
    if (cs_w) acc_run++;
    else acc_run = 0;
    if (dm_ww_w) nw_w++;
    if (dm_wb_w) nb_w++;
    if (dm_wh_w) begin
      nh_w++;
      h_pos = acc_run;
    end
  end

  // One request on the WAIT_CYCLES=0 instance; lat counts cycles from accept to resp_valid.
  task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err, output int lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rd  = resp_rdata;
    err = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;
  int          w0, h0, b0, c0, held;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst0_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = '0; req_addr = '0; req_wdata = '0;
    rstw_n = 1'b0; req_valid_w = 1'b0; resp_ready_w = 1'b0;
    req_op_w = '0; req_addr_w = '0; req_wdata_w = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst0_n = 1'b1;
    rstw_n = 1'b1;

    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_cs_r", {30'd0, cs, dm_r}, 32'd0);
    check("rst_strobes", {29'd0, dm_ww, dm_wh, dm_wb}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_addr", 32'(dm_addr), 32'd0);
    check("rst_wdata", dm_din, 32'd0);

    // SW then LW at offset 0
    w0 = nw; h0 = nh; b0 = nb;
    run_req(3'd7, 32'h1001_0000, 32'hDEAD_BEEF, rd, err, lat);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_err", 32'(err), 32'd0);
    check("sw_rdata", rd, 32'd0);
    check("sw_w_pulses", 32'(nw - w0), 32'd1);
    check("sw_other_pulses", 32'((nh - h0) + (nb - b0)), 32'd0);
    check("sw_addr", 32'(last_addr), 32'd0);
    check("sw_data", last_data, 32'hDEAD_BEEF);
    check("sw_ready_after", 32'(req_ready), 32'd1);

    w0 = nw; h0 = nh; b0 = nb;
    run_req(3'd4, 32'h1001_0000, 32'h0, rd, err, lat);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_rdata", rd, 32'hDEAD_BEEF);
    check("lw_err", 32'(err), 32'd0);
    check("lw_no_strobe", 32'((nw - w0) + (nh - h0) + (nb - b0)), 32'd0);

    // bytes 0x80,0xFF at offset 4
    h0 = nh;
    run_req(3'd6, 32'h1001_0004, 32'h0000_FF80, rd, err, lat);
    check("sh_h_pulses", 32'(nh - h0), 32'd1);
    check("sh_addr", 32'(last_addr), 32'd4);
    run_req(3'd0, 32'h1001_0004, 32'h0, rd, err, lat);
    check("lb_sext", rd, 32'hFFFF_FF80);
    run_req(3'd1, 32'h1001_0004, 32'h0, rd, err, lat);
    check("lbu_zext", rd, 32'h0000_0080);
    run_req(3'd2, 32'h1001_0004, 32'h0, rd, err, lat);
    check("lh_sext", rd, 32'hFFFF_FF80);
    run_req(3'd3, 32'h1001_0004, 32'h0, rd, err, lat);
    check("lhu_zext", rd, 32'h0000_FF80);

    w0 = nw; h0 = nh; b0 = nb;
    run_req(3'd5, 32'h1001_0005, 32'h1234_56AB, rd, err, lat);
    check("sb_b_pulses", 32'(nb - b0), 32'd1);
    check("sb_other_pulses", 32'((nw - w0) + (nh - h0)), 32'd0);
    check("sb_addr", 32'(last_addr), 32'd5);
    run_req(3'd4, 32'h1001_0004, 32'h0, rd, err, lat);
    check("sb_readback", rd, 32'h0000_AB80);

    // range boundaries
    c0 = ncs;
    run_req(3'd4, 32'h1001_03FD, 32'h0, rd, err, lat);
    check("oob_err", 32'(err), 32'd1);
    check("oob_rdata", rd, 32'd0);
    check("oob_lat", 32'(lat), 32'd1);
    check("oob_no_cs", 32'(ncs - c0), 32'd0);
    run_req(3'd7, 32'h1001_03FC, 32'hCAFE_F00D, rd, err, lat);
    check("top_sw_err", 32'(err), 32'd0);
    run_req(3'd4, 32'h1001_03FC, 32'h0, rd, err, lat);
    check("top_lw_err", 32'(err), 32'd0);
    check("top_lw_rdata", rd, 32'hCAFE_F00D);
    c0 = ncs;
    run_req(3'd4, 32'h1000_FFFC, 32'h0, rd, err, lat);
    check("below_err", 32'(err), 32'd1);
    check("below_lat", 32'(lat), 32'd1);
    check("below_no_cs", 32'(ncs - c0), 32'd0);

    // misaligned half: mem[1]=BE, mem[2]=AD
    c0 = ncs;
    run_req(3'd2, 32'h1001_0001, 32'h0, rd, err, lat);
`ifdef DMEM_ACCESS_ALIGN_CHECK_EN
    check("mis_err", 32'(err), 32'd1);
    check("mis_rdata", rd, 32'd0);
    check("mis_no_cs", 32'(ncs - c0), 32'd0);
`else
    check("mis_err", 32'(err), 32'd0);
    check("mis_rdata", rd, 32'hFFFF_ADBE);
    check("mis_cs", 32'(ncs - c0), 32'd1);
`endif
    check("no_multi_strobe", 32'(nmulti), 32'd0);

    // WAIT_CYCLES=3: SH strobe only in 4th ACCESS cycle
    @(negedge clk);
    req_valid_w = 1'b1; req_op_w = 3'd6; req_addr_w = 32'h1001_0010; req_wdata_w = 32'h0000_BEEF;
    h0 = nh_w; w0 = nw_w; b0 = nb_w;
    @(posedge clk);
    #1;
    req_valid_w = 1'b0;
    lat = 1;
    while (!resp_valid_w && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("w3_sh_lat", 32'(lat), 32'd5);
    check("w3_sh_pulses", 32'(nh_w - h0), 32'd1);
    check("w3_sh_pos", 32'(h_pos), 32'd4);
    check("w3_sh_other", 32'((nw_w - w0) + (nb_w - b0)), 32'd0);
    resp_ready_w = 1'b1;
    @(posedge clk);
    #1;
    resp_ready_w = 1'b0;

    // WAIT_CYCLES=3 load with resp_ready held low for 5 cycles
    @(negedge clk);
    req_valid_w = 1'b1; req_op_w = 3'd4; req_addr_w = 32'h1001_0040;
    @(posedge clk);
    #1;
    req_valid_w = 1'b0;
    lat = 1;
    while (!resp_valid_w && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("w3_lw_lat", 32'(lat), 32'd5);
    held = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid_w && !req_ready_w && !resp_err_w && resp_rdata_w == 32'h1234_5678) held++;
      @(posedge clk);
      #1;
    end
    check("w3_hold_cycles", 32'(held), 32'd5);
    check("w3_lw_rdata", resp_rdata_w, 32'h1234_5678);
    resp_ready_w = 1'b1;
    @(posedge clk);
    #1;
    resp_ready_w = 1'b0;
    check("w3_ready_after", 32'(req_ready_w), 32'd1);

    // reset during ACCESS of an SW aborts before any strobe
    @(negedge clk);
    req_valid_w = 1'b1; req_op_w = 3'd7; req_addr_w = 32'h1001_0020; req_wdata_w = 32'h5555_AAAA;
    w0 = nw_w; h0 = nh_w; b0 = nb_w;
    @(posedge clk);
    #1;
    req_valid_w = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_cs", 32'(cs_w), 32'd1);
    rstw_n = 1'b0;
    @(posedge clk);
    #1;
    rstw_n = 1'b1;
    check("rst_mid_ready", 32'(req_ready_w), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("rst_mid_no_strobe", 32'((nw_w - w0) + (nh_w - h0) + (nb_w - b0)), 32'd0);
    check("rst_mid_idle", {30'd0, cs_w, resp_valid_w}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
